// File: rtl/vec_alu_pkg.sv
// Shared op encodings, reservation-table entry and default ALU latencies
// for the vector ALU scheduler.
package vec_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_FMA = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  // Wide enough for the largest supported requester count (8).
  localparam int RES_IDW = 3;

  typedef struct packed {
    logic               valid;
    logic [RES_IDW-1:0] id;
    logic               err;
  } res_ent_t;

  localparam int DEF_LAT_ADD = 2;
  localparam int DEF_LAT_MUL = 2;
  localparam int DEF_LAT_FMA = 4;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant to the first eligible
// index at or after the pointer; pointer moves to grant+1 and holds when idle.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  elig,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!gnt_vld && elig[cand[IW-1:0]]) begin
        gnt_vld                = 1'b1;
        gnt_idx                = cand[IW-1:0];
        grant[cand[IW-1:0]]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vec_alu_sched.sv
// Shares one pipelined vector ALU among NUM_REQ requesters; result returns L+1 cycles after issue,
// no response backpressure. VEC_ALU_SCHED_PERF_EN adds issue/conflict counters.
module vec_alu_sched
  import vec_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ELE_NUM = 8,
  parameter int LAT_ADD = DEF_LAT_ADD,
  parameter int LAT_MUL = DEF_LAT_MUL,
  parameter int LAT_FMA = DEF_LAT_FMA,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*32*ELE_NUM-1:0] req_a,
  input  logic [NUM_REQ*32*ELE_NUM-1:0] req_b,
  input  logic [NUM_REQ*32*ELE_NUM-1:0] req_c,
  output logic                         alu_valid,
  output logic [1:0]                   alu_ctrl,
  output logic [32*ELE_NUM-1:0]        alu_a,
  output logic [32*ELE_NUM-1:0]        alu_b,
  output logic [32*ELE_NUM-1:0]        alu_c,
  input  logic [32*ELE_NUM-1:0]        alu_d,
  output logic                         rsp_valid,
  output logic [IDW-1:0]               rsp_id,
  output logic                         rsp_err,
  output logic [32*ELE_NUM-1:0]        rsp_data,
  output logic                         busy
`ifdef VEC_ALU_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_issue_cnt,
  output logic [31:0]                  perf_conflict_cnt
`endif
);

  localparam int VW = 32 * ELE_NUM;

  res_ent_t tab     [LAT_FMA];
  res_ent_t sh_tab  [LAT_FMA];
  res_ent_t nxt_tab [LAT_FMA];

  logic [NUM_REQ-1:0] slot_busy;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_vld;
  logic [1:0]         op_g;
  logic               unused_id_hi;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      OP_MUL:  return LAT_MUL;
      OP_FMA:  return LAT_FMA;
      default: return LAT_ADD;
    endcase
  endfunction

  // sh_tab is the table as it will look after this cycle's shift.
  always_comb begin
    for (int s = 0; s < LAT_FMA-1; s++) sh_tab[s] = tab[s+1];
    sh_tab[LAT_FMA-1] = '0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_busy[i] = 1'b0;
      for (int s = 0; s < LAT_FMA; s++)
        if (s == lat_of(req_op[2*i +: 2]) - 1 && sh_tab[s].valid) slot_busy[i] = 1'b1;
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .elig    (req_valid & ~slot_busy),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    op_g  = '0;
    alu_a = '0;
    alu_b = '0;
    alu_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_g  = op_g  | (req_op[2*i +: 2]  & {2{grant[i]}});
      alu_a = alu_a | (req_a[i*VW +: VW] & {VW{grant[i]}});
      alu_b = alu_b | (req_b[i*VW +: VW] & {VW{grant[i]}});
      alu_c = alu_c | (req_c[i*VW +: VW] & {VW{grant[i]}});
    end
  end

  assign req_ready = grant;
  assign alu_valid = gnt_vld;
  assign alu_ctrl  = op_g;

  always_comb begin
    nxt_tab = sh_tab;
    for (int s = 0; s < LAT_FMA; s++)
      if (gnt_vld && s == lat_of(op_g) - 1)
        nxt_tab[s] = '{valid: 1'b1, id: RES_IDW'(gnt_idx), err: (op_g == OP_ILL)};
  end

  // Slot 0 lines up with the ALU result presented this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tab       <= '{default: '0};
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      tab       <= nxt_tab;
      rsp_valid <= tab[0].valid;
      rsp_id    <= tab[0].id[IDW-1:0];
      rsp_err   <= tab[0].valid & tab[0].err;
      rsp_data  <= tab[0].valid ? alu_d : '0;
    end
  end

  assign unused_id_hi = |tab[0].id;

  always_comb begin
    busy = rsp_valid;
    for (int s = 0; s < LAT_FMA; s++) busy = busy | tab[s].valid;
  end

`ifdef VEC_ALU_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (gnt_vld) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (|(req_valid & slot_busy)) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_alu_sched.sv
// Directed bench for vec_alu_sched with a behavioural pipelined ALU and a
// response scoreboard filled at each handshake.
`timescale 1ns/1ps
module tb_vec_alu_sched;
  localparam int NR = 4;
  localparam int EN = 8;
  localparam int VW = 32 * EN;
  localparam int LA = 2;
  localparam int LM = 2;
  localparam int LF = 4;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [2*NR-1:0]   req_op;
  logic [NR*VW-1:0]  req_a, req_b, req_c;
  logic              alu_valid;
  logic [1:0]        alu_ctrl;
  logic [VW-1:0]     alu_a, alu_b, alu_c, alu_d;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic              rsp_err;
  logic [VW-1:0]     rsp_data;
  logic              busy;
`ifdef VEC_ALU_SCHED_PERF_EN
  logic [31:0]       perf_issue_cnt, perf_conflict_cnt;
  logic [31:0]       pi0, pc0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int            id;
    logic          err;
    logic [VW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq [$];
  exp_t          push_e, pop_e;
  logic [VW-1:0] alu_mem [16];
  logic [31:0]   fv [4];
  logic [NR-1:0] exp_gnt;
  int            exp_ptr;

  vec_alu_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .alu_valid(alu_valid), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy)
`ifdef VEC_ALU_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign alu_d = alu_mem[cyc[3:0]];

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] de;
    if (r == 0.0) return 32'd0;
    d  = $realtobits(r);
    de = d[62:52];
    return {d[63], 8'(int'(de) - 896), d[51:29]};
  endfunction

  function automatic logic [VW-1:0] alu_model(input logic [1:0] op, input logic [VW-1:0] a,
                                              input logic [VW-1:0] b, input logic [VW-1:0] c);
    logic [VW-1:0] d;
    real x, y, z;
    d = '0;
    for (int l = 0; l < EN; l++) begin
      x = f2r(a[32*l +: 32]);
      y = f2r(b[32*l +: 32]);
      z = f2r(c[32*l +: 32]);
      case (op)
        2'b00:   d[32*l +: 32] = r2f(x + y);
        2'b01:   d[32*l +: 32] = r2f(x * y);
        2'b10:   d[32*l +: 32] = r2f(x * y + z);
        default: d[32*l +: 32] = 32'd0;
      endcase
    end
    return d;
  endfunction

  function automatic int lat(input logic [1:0] op);
    case (op)
      2'b01:   return LM;
      2'b10:   return LF;
      default: return LA;
    endcase
  endfunction

  function automatic logic [VW-1:0] splat(input logic [31:0] f);
    return {EN{f}};
  endfunction

  // ALU model and scoreboard, both sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_valid) alu_mem[4'(cyc + lat(alu_ctrl))] <= alu_model(alu_ctrl, alu_a, alu_b, alu_c);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          push_e.id   = i;
          push_e.err  = (req_op[2*i +: 2] == 2'b11);
          push_e.data = alu_model(req_op[2*i +: 2], req_a[i*VW +: VW], req_b[i*VW +: VW], req_c[i*VW +: VW]);
          push_e.due  = cyc + lat(req_op[2*i +: 2]) + 1;
          sbq.push_back(push_e);
        end
      end
      if (rsp_valid) begin
        chk("rsp_expected", (sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          pop_e = sbq.pop_front();
          chk("rsp_id", rsp_id, pop_e.id);
          chk("rsp_err", rsp_err, pop_e.err);
          chk("rsp_data", rsp_data, pop_e.data);
          chk("rsp_cycle", cyc, pop_e.due);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
    req_valid[i]       = v;
    req_op[2*i +: 2]   = op;
    req_a[i*VW +: VW]  = a;
    req_b[i*VW +: VW]  = b;
    req_c[i*VW +: VW]  = c;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pending"}, sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fv[0] = F1; fv[1] = F2; fv[2] = F3; fv[3] = F4;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single add, 1.0 + 1.0
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'b00, splat(F1), splat(F1), '0);
    @(negedge clk);
    chk("add_ready", req_ready, 4'b0001);
    chk("add_alu_valid", alu_valid, 1);
    chk("add_alu_a", alu_a, splat(F1));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("add_busy", busy, 1);
    chk("idle_alu_a", alu_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_data", rsp_data, splat(F2));
    wait_idle("add_drain");

    // round robin, all requesters busy; pointer sits at 1 after the add
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'b00, splat(fv[i]), splat(F2), '0);
    exp_ptr = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_gnt = NR'(1) << exp_ptr;
      chk("rr_grant", req_ready, exp_gnt);
      exp_ptr = (exp_ptr + 1) % NR;
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle("rr_drain");

    // slot conflict: fma from req0, add from req1 two cycles later
`ifdef VEC_ALU_SCHED_PERF_EN
    pi0 = perf_issue_cnt;
    pc0 = perf_conflict_cnt;
`endif
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'b10, splat(F2), splat(F3), splat(F1));
    @(negedge clk);
    chk("fma_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    set_req(1, 1'b1, 2'b00, splat(F4), splat(F1), '0);
    @(negedge clk);
    chk("conflict_block", req_ready, 4'b0000);
    chk("conflict_alu_valid", alu_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("conflict_grant", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("conflict_drain");
`ifdef VEC_ALU_SCHED_PERF_EN
    chk("perf_issue", perf_issue_cnt - pi0, 2);
    chk("perf_conflict", perf_conflict_cnt - pc0, 1);
`endif

    // illegal op from req2
    @(posedge clk); #1;
    set_req(2, 1'b1, 2'b11, splat(F1), splat(F1), '0);
    @(negedge clk);
    chk("ill_ready", req_ready, 4'b0100);
    chk("ill_ctrl", alu_ctrl, 2'b11);
    @(posedge clk); #1 req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ill_rsp_valid", rsp_valid, 1);
    chk("ill_rsp_err", rsp_err, 1);
    chk("ill_rsp_id", rsp_id, 2);
    wait_idle("ill_drain");

    // three fma in flight, then asynchronous reset
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'b10, splat(F1), splat(F2), splat(F3));
    set_req(1, 1'b1, 2'b10, splat(F2), splat(F2), splat(F1));
    set_req(3, 1'b1, 2'b10, splat(F3), splat(F1), splat(F1));
    @(negedge clk);
    chk("rstm_grant_a", req_ready, 4'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstm_grant_b", req_ready, 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstm_grant_c", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    chk("rstm_busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstm_rsp_valid", rsp_valid, 0);
    chk("rstm_busy", busy, 0);
    sbq.delete();
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rstm_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    set_req(2, 1'b1, 2'b00, splat(F1), splat(F2), '0);
    set_req(0, 1'b1, 2'b00, splat(F3), splat(F1), '0);
    @(negedge clk);
    chk("rstm_next_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
